// File: rtl/booth_mac_seq_pkg.sv
// Shared types and widths for the Booth multiply-accumulate sequencer.
package booth_mac_pkg;

    localparam int MUL_W     = 16;
    localparam int PROD_W    = 32;
    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/booth_mac_seq_if.sv
// Operand input stream and accumulated-result output stream of booth_mac_seq.
interface booth_mac_seq_if
    import booth_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [MUL_W-1:0] in_a;
    logic signed [MUL_W-1:0] in_b;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0]        out_count;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count
    );

endinterface

// File: rtl/booth_mac_seq_mul.sv
// Sequential radix-2 Booth multiplier: loads on the first enabled edge, then 16 steps, then done.
module Booth_mul
    import booth_mac_pkg::*;
(
    input  logic                     clk,
    input  logic                     en,
    input  logic signed [MUL_W-1:0]  A,
    input  logic signed [MUL_W-1:0]  B,
    output logic signed [PROD_W-1:0] Prod,
    output logic                     done
);

    logic [4:0]            cnt;
    logic signed [MUL_W:0] m;
    logic signed [MUL_W:0] hi;
    logic [MUL_W-1:0]      lo;
    logic                  qm1;
    logic signed [MUL_W:0] sum;

    // Partial product keeps one guard bit so the add/subtract never overflows.
    always_comb begin
        sum = hi;
        case ({lo[0], qm1})
            2'b01:   sum = hi + m;
            2'b10:   sum = hi - m;
            default: sum = hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!en) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (cnt == 5'd0) begin
            m   <= {A[MUL_W-1], A};
            hi  <= '0;
            lo  <= B;
            qm1 <= 1'b0;
            cnt <= 5'd1;
        end else if (cnt <= 5'd16) begin
            hi  <= {sum[MUL_W], sum[MUL_W:1]};
            lo  <= {sum[0], lo[MUL_W-1:1]};
            qm1 <= lo[0];
            cnt <= cnt + 5'd1;
        end else begin
            done <= 1'b1;
        end
    end

    assign Prod = {hi[MUL_W-1:0], lo};

endmodule

// File: rtl/booth_mac_seq.sv
// Feeds operand pairs to Booth_mul and accumulates products into a per-group dot product.
module booth_mac_seq
    import booth_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
)(
    input logic           clk,
    input logic           rst,
    booth_mac_seq_if.slave bus
);

    state_t                   state_q;
    state_t                   state_d;
    logic signed [MUL_W-1:0]  a_q;
    logic signed [MUL_W-1:0]  b_q;
    logic                     last_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [CNT_W-1:0]         count_q;
    logic [CNT_W-1:0]         count_inc;
    logic signed [ACC_W-1:0]  out_acc_q;
    logic [CNT_W-1:0]         out_count_q;
    logic                     mul_en;
    logic                     mul_done;
    logic signed [PROD_W-1:0] prod;

    Booth_mul u_mul (
        .clk  (clk),
        .en   (mul_en),
        .A    (a_q),
        .B    (b_q),
        .Prod (prod),
        .done (mul_done)
    );

    // Held low through reset so the multiplier is cleared before the next element.
    assign mul_en    = (state_q == RUN) && !rst;
    assign prod_ext  = ACC_W'(prod);
    assign acc_sum   = acc_q + prod_ext;
    assign count_inc = count_q + CNT_W'(1);

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_acc   = out_acc_q;
    assign bus.out_count = out_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = RUN;
            RUN:  if (mul_done)     state_d = last_q ? HOLD : IDLE;
            HOLD: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            out_acc_q   <= '0;
            out_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.in_a;
                        b_q    <= bus.in_b;
                        last_q <= bus.in_last;
                    end
                end
                RUN: begin
                    if (mul_done) begin
                        acc_q   <= acc_sum;
                        count_q <= count_inc;
                        if (last_q) begin
                            out_acc_q   <= acc_sum;
                            out_count_q <= count_inc;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        acc_q   <= '0;
                        count_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/booth_mac_seq.md
# booth_mac_seq

Operand sequencer and accumulator that sits directly around the 16-bit Booth multiplier (`Booth_mul`). It accepts signed operand pairs over a valid/ready stream and drives the multiplier's `en`/`A`/`B`. It then waits for `done` and adds each signed 32-bit product into a wide accumulator. When the element flagged `in_last` is accumulated, it presents the accumulated dot product downstream over a second valid/ready handshake.

## Interface
- `ACC_W`, 40: accumulator and `out_acc` width, signed. Must be at least 32.
- `CNT_W`, 8: width of the element counter and `out_count`.
- `clk` in 1: clock. All logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `in_a` in 16: signed multiplicand.
- `in_b` in 16: signed multiplier.
- `in_last` in 1: this pair closes the current group.
- `out_valid` out 1: accumulated result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_acc` out ACC_W: signed sum of products for the group.
- `out_count` out CNT_W: number of pairs in the group.

## Operation
- States:
  - IDLE: `in_ready`=1, `mul_en`=0.
  - RUN: `mul_en`=1, waiting for `done`.
  - HOLD: `out_valid`=1, waiting for `out_ready`.
- IDLE, on `in_valid & in_ready`:
  - Latch `in_a` into `a_q`, `in_b` into `b_q`, `in_last` into `last_q`.
  - Go to RUN.
- RUN, on an edge where the multiplier's `done`=1:
  - `acc <= acc + sext(Prod)` and `count <= count + 1`.
  - Go to HOLD if `last_q`, else go to IDLE.
- HOLD, on an edge where `out_ready`=1:
  - `acc <= 0`, `count <= 0`, `out_valid <= 0`.
  - Go to IDLE.
- The multiplier sees `en = (state == RUN)`, `A = a_q`, `B = b_q`.
  - IDLE always lasts at least one cycle with `en`=0, so the multiplier's counter and `done` are cleared before every element.
- Arithmetic:
  - `Prod` is sign-extended from 32 bits to `ACC_W` bits.
  - The accumulator wraps modulo 2^ACC_W; there is no saturation.
  - `count` wraps modulo 2^CNT_W.
- `out_acc` and `out_count` are registered from `acc` and `count` on the edge that enters HOLD. They stay stable while `out_valid & ~out_ready`.
- `in_valid` is ignored in RUN and HOLD; `in_ready`=0 there.
- Supported operand range is -32767..32767. The result for an operand of -32768 is unspecified.
- Reset (any state, including mid-RUN or mid-HOLD):
  - State goes to IDLE.
  - `acc`, `count`, `a_q`, `b_q`, `last_q`, `out_acc`, `out_count`, `out_valid` all go to 0.
  - `in_ready` is forced to 0 while `rst`=1.
  - `en`=0 during and after reset, which clears the multiplier on the next edge.

## Timing
- Reset values:
  - `in_ready`=0 while in reset, 1 on the first cycle after reset.
  - `out_valid`=0, `out_acc`=0, `out_count`=0.
- Accept at edge E:
  - Multiplier loads at E+1 and completes 16 steps by E+17.
  - `done` is visible after E+18.
  - Accumulation and the state exit happen at E+19.
- `in_ready` returns to 1 in the cycle after E+19. Maximum throughput is one pair per 20 cycles.
- For a last element, `out_valid` rises in the cycle after E+19, with `out_acc` already updated.
- Handshake on `out_ready` at edge H: `out_valid`=0 after H, and `in_ready`=1 after H.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Structure
- Package `booth_mac_pkg` holds:
  - the state enum (IDLE/RUN/HOLD);
  - `MUL_W`=16 and `PROD_W`=32;
  - the default `ACC_W`=40 and `CNT_W`=8.
- One sub-module: a single `Booth_mul` instance. Everything else is inline FSM, datapath registers and the adder.

## Test plan
- Single element, A=3, B=-5, last=1:
  - `out_acc` = -15 (0xFF_FFFF_FFF1 at ACC_W=40) and `out_count`=1.
  - `out_valid` rises exactly 20 cycles after the accept edge.
- Three-pair group (100,200), (-7,9), (32767,32767):
  - `out_acc` = 1073696226 and `out_count`=3.
  - `in_ready` re-asserts exactly 20 cycles after each accept.
- Backpressure: hold `out_ready`=0 for 10 cycles with `in_valid`=1 throughout.
  - `in_ready` stays 0 and `out_acc`/`out_count` stay stable.
  - After `out_ready`=1, the next group starts from `acc`=0.
- Wrap at ACC_W=32: three pairs of (32767,32767).
  - `out_acc` = -1073938429 (mod 2^32) and `out_count`=3.
- Reset mid-RUN: assert `rst` 10 cycles after an accept.
  - All outputs go to 0 and `in_ready`=0 during reset.
  - A following group (2,2,last) yields `out_acc`=4, `out_count`=1.
